// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Purpose:
//   Generates the machine-cycle timing for a small CPU clocked from a 50 MHz
//   board clock. Each machine cycle lasts DIV clocks. During a cycle,
//   NUM_PH one-clock phase-enable pulses are emitted at evenly spaced points.
//   The sequencer can free-run, halt, or single-step from a debounced push
//   button. A cycle that has started always runs to completion.
//
// Parameters:
//   DIV     - CLOCK_50 clocks per machine cycle (DIV >= 2, DIV >= 2*NUM_PH)
//   NUM_PH  - number of phase-enable channels (>= 1)
//   DBNC    - step-key debounce length in clocks (>= 1)
//   CNT_W   - width of the completed-cycle counter
//
// Ports:
//   CLOCK_50  in   1       sole clock, rising edge
//   res       in   1       synchronous active-low reset
//   mode      in   2       00 run, 01 halt, 10 single-step, 11 halt
//   step_key  in   1       raw push-button, active-low (released = 1)
//   phi       out  NUM_PH  one-clock phase-enable pulses
//   phi_level out  1       machine-clock square wave for LEDs/probes
//   running   out  1       high while a machine cycle is in progress
//   cycle_cnt out  CNT_W   number of completed machine cycles (wraps)
// ---------------------------------------------------------------------------
module phase_sequencer #(
  parameter int DIV    = 50,
  parameter int NUM_PH = 3,
  parameter int DBNC   = 500000,
  parameter int CNT_W  = 32
) (
  input  logic              CLOCK_50,
  input  logic              res,
  input  logic [1:0]        mode,
  input  logic              step_key,
  output logic [NUM_PH-1:0] phi,
  output logic              phi_level,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DBW = (DBNC > 1) ? $clog2(DBNC) : 1;

  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STEP_CYC = 2'd2;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic [1:0]       r_state;
  logic [DW-1:0]    r_divCnt;
  logic [CNT_W-1:0] r_cycleCnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_dbLevel;
  logic             r_dbPrev;
  logic [DBW-1:0]   r_dbCnt;

  logic w_active;
  logic w_cycleEnd;
  logic w_stepPulse;

  assign w_active   = (r_state != ST_STOPPED);
  assign w_cycleEnd = w_active && (r_divCnt == DW'(DIV - 1));

  // Two-flop synchronizer for the asynchronous push-button. Idles high so
  // that a released key looks released straight out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (!res) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= step_key;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: the debounced level follows the synchronized key only once
  // the two have disagreed for DBNC consecutive clocks. Any clock on which
  // they agree again throws away the partial count.
  always_ff @(posedge CLOCK_50) begin
    if (!res) begin
      r_dbLevel <= 1'b1;
      r_dbCnt   <= '0;
    end else if (r_sync2 != r_dbLevel) begin
      if (r_dbCnt == DBW'(DBNC - 1)) begin
        r_dbLevel <= r_sync2;
        r_dbCnt   <= '0;
      end else begin
        r_dbCnt <= r_dbCnt + DBW'(1);
      end
    end else begin
      r_dbCnt <= '0;
    end
  end

  // Delayed copy of the debounced level, used to find the press edge.
  always_ff @(posedge CLOCK_50) begin
    if (!res) begin
      r_dbPrev <= 1'b1;
    end else begin
      r_dbPrev <= r_dbLevel;
    end
  end

  // One-clock pulse on a debounced press (1 -> 0).
  assign w_stepPulse = r_dbPrev && !r_dbLevel;

  // Sequencer FSM and cycle divider. The divider sits at 0 while stopped so
  // that entering RUN or STEP_CYC lands directly on the first phase. A cycle
  // only ends on the DIV-1 clock, so mode changes never cut a cycle short.
  // Step pulses seen outside STOPPED+single-step simply vanish.
  always_ff @(posedge CLOCK_50) begin
    if (!res) begin
      r_state    <= ST_STOPPED;
      r_divCnt   <= '0;
      r_cycleCnt <= '0;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          r_divCnt <= '0;
          if (mode == MODE_RUN) begin
            r_state <= ST_RUN;
          end else if ((mode == MODE_STEP) && w_stepPulse) begin
            r_state <= ST_STEP_CYC;
          end
        end
        ST_RUN, ST_STEP_CYC: begin
          if (w_cycleEnd) begin
            r_divCnt   <= '0;
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            if ((r_state == ST_RUN) && (mode == MODE_RUN)) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_STOPPED;
            end
          end else begin
            r_divCnt <= r_divCnt + DW'(1);
          end
        end
        default: begin
          r_state  <= ST_STOPPED;
          r_divCnt <= '0;
        end
      endcase
    end
  end

  // Phase decode: purely from registered state and divider, so no input can
  // reach phi combinationally. Channel k fires at k*(DIV/NUM_PH).
  for (genvar k = 0; k < NUM_PH; k++) begin : g_phi
    localparam int PH_POS = k * (DIV / NUM_PH);
    assign phi[k] = w_active && (r_divCnt == DW'(PH_POS));
  end

  assign phi_level = w_active && (r_divCnt < DW'(DIV / 2));
  assign running   = w_active;
  assign cycle_cnt = r_cycleCnt;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 50: CLOCK_50 clocks per machine cycle; legal values DIV >= 2 and DIV >= 2*NUM_PH.
REQ-002 SHALL have parameter NUM_PH, default 3: number of phase-enable channels; NUM_PH >= 1.
REQ-003 SHALL have parameter DBNC, default 500000: step-key debounce length in clocks; DBNC >= 1.
REQ-004 SHALL have parameter CNT_W, default 32: width of the machine-cycle counter.
REQ-005 SHALL have port CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port res  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port mode  in  2  00 run, 01 halt, 10 single-step, 11 treated as halt.
REQ-008 SHALL have port step_key  in  1  raw asynchronous push-button; active-low, released = 1.
REQ-009 SHALL have port phi  out  NUM_PH  one-clock phase-enable pulses, one bit per channel.
REQ-010 SHALL have port phi_level  out  1  machine-clock square wave for LEDs and probes.
REQ-011 SHALL have port running  out  1  high while a machine cycle is in progress.
REQ-012 SHALL have port cycle_cnt  out  CNT_W  count of completed machine cycles.

Function
REQ-013 SHALL implement states STOPPED, RUN and STEP_CYC, plus a divider div_cnt counting 0..DIV-1 that is held at 0 in STOPPED.
REQ-014 STOPPED SHALL go to RUN when mode=00, go to STEP_CYC when mode=10 and step_pulse=1, and otherwise remain STOPPED.
REQ-015 In RUN and STEP_CYC, div_cnt SHALL increment each clock and wrap from DIV-1 to 0; the clock with div_cnt=DIV-1 completes a machine cycle.
REQ-016 At cycle completion, RUN SHALL stay in RUN if mode=00 and otherwise go to STOPPED; STEP_CYC SHALL always go to STOPPED.
REQ-017 A mode change mid-cycle SHALL never truncate the cycle; every started cycle emits all NUM_PH phase pulses.
REQ-018 phi[k] SHALL be 1 for exactly the one clock where the state is RUN or STEP_CYC and div_cnt = k*(DIV/NUM_PH), using integer division; otherwise phi[k] SHALL be 0.
REQ-019 phi SHALL be decoded only from registered state and div_cnt, with no combinational path from mode or step_key.
REQ-020 phi_level SHALL be 1 when the state is active and div_cnt < DIV/2, and 0 otherwise.
REQ-021 running SHALL be 1 exactly when the state is not STOPPED.
REQ-022 cycle_cnt SHALL increment by 1 on each completed cycle and wrap modulo 2^CNT_W.
REQ-023 step_key SHALL pass through a 2-flop synchronizer before use.
REQ-024 The debounced level SHALL change only after the synchronized input differs from it for DBNC consecutive clocks; any disagreement shorter than DBNC SHALL restart the count.
REQ-025 step_pulse SHALL be a one-clock internal pulse on a debounced 1->0 transition.
REQ-026 step_pulse SHALL be ignored unless the state is STOPPED and mode=10; ignored presses are not queued.
REQ-027 From STOPPED with mode=00 sampled at edge N, the state SHALL be RUN with div_cnt=0 after edge N, so that phi[0] is high in the clock following edge N.

Reset
REQ-028 While res=0 at a clock edge, the block SHALL set: state STOPPED, div_cnt 0, cycle_cnt 0, synchronizer flops 1, debounced level 1, debounce count 0.
REQ-029 Reset SHALL take priority over every other event, including reset asserted mid-cycle.
REQ-030 During and immediately after reset, outputs SHALL be phi=0, phi_level=0, running=0, cycle_cnt=0.

Verification (DIV=6, NUM_PH=3, DBNC=4, CNT_W=4)
REQ-031 Free-run: res=0 for 3 clocks, then res=1 with mode=00 -> phi[0] at clocks 1, 7, 13; phi[1] at 3, 9; phi[2] at 5, 11; phi_level high on clocks 1-3 and 7-9; cycle_cnt=2 after clock 12.
REQ-032 Halt mid-cycle: mode=01 when div_cnt=2 -> phi[1] and phi[2] still pulse; cycle_cnt increments once; running=0 with phi silent afterwards.
REQ-033 Step: mode=10, step_key low for 6 clocks -> exactly one cycle (3 pulses), cycle_cnt +1, then STOPPED; a 3-clock low glitch -> no cycle.
REQ-034 Second press during an active STEP_CYC -> ignored, cycle_cnt +1 only; after return to STOPPED a new press -> one further cycle.
REQ-035 Reset at div_cnt=3 in RUN -> the next clock shows phi=0, running=0, cycle_cnt=0.
REQ-036 Wrap: 17 consecutive run cycles -> cycle_cnt reads 15 then 0 then 1.
